// File: rtl/memio_pkg.sv
// Shared constants and helpers for the memory/IO responder.
// Holds the IO window select, IO register offsets, stop FSM state
// encodings and a byte-select helper for the cycle counter snapshot.
package memio_pkg;

    // mem_a[17:16] value that selects the IO window at 0x30000.
    localparam logic [1:0] IO_SEL = 2'b11;

    // IO register offsets (mem_a[2:0]).
    localparam logic [2:0] IO_UART = 3'd0;
    localparam logic [2:0] IO_CLK  = 3'd4;

    // Stop FSM states.
    typedef logic [1:0] stop_state_t;
    localparam stop_state_t ST_RUN     = 2'd0;
    localparam stop_state_t ST_DRAIN   = 2'd1;
    localparam stop_state_t ST_STOPPED = 2'd2;

    // Little-endian byte select from a 32-bit word.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/memio_fifo.sv
// Synchronous FIFO used for the UART tx and rx queues.
// Ports: clk, rst (async active-high), push/push_data, pop,
//        head_c (combinational view of the oldest entry), count.
// A push into a full FIFO is dropped unless a pop frees a slot in the
// same cycle; a pop of an empty FIFO does nothing, so a byte pushed into
// an empty FIFO is never visible to a same-cycle pop.
module memio_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_pop;
    logic             do_push;

    // Accepted operations; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
    end

    assign head_c = mem[rd_ptr];

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage, not reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory/IO responder for the CPU byte bus.
// Backs a 2^ADDR_WIDTH byte RAM and the IO window at 0x30000 (UART tx/rx,
// 32-bit cycle counter snapshot, program stop).
// Ports: clk_in, rst_in (async active-high), rdy_in gates bus requests;
//        mem_a/mem_wr/mem_dout request, mem_din registered read data;
//        io_buffer_full tx almost-full; tx_data/tx_valid/tx_ready UART tx;
//        rx_data/rx_valid UART rx push; program_stop sticky stop flag;
//        tx_overflow sticky tx drop flag (only with MEMIO_TX_OVERFLOW_FLAG_EN).
module mem_io_responder
    import memio_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned TX_DEPTH   = 8,
    parameter int unsigned RX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_stop
`ifdef MEMIO_TX_OVERFLOW_FLAG_EN
    ,
    output logic        tx_overflow
`endif
);

    localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;

    logic [7:0]       ram [2**ADDR_WIDTH];
    logic             io_sel;
    logic [2:0]       io_off;
    logic             bus_rd;
    logic             bus_wr;
    logic [7:0]       rd_data;
    logic             tx_push;
    logic [7:0]       tx_push_data;
    logic             tx_pop;
    logic [TX_CW-1:0] tx_count;
    logic             rx_pop;
    logic [7:0]       rx_head;
    logic [RX_CW-1:0] rx_count;
    logic             stop_req;
    logic [31:0]      cycle_cnt;
    logic [31:0]      snapshot;
    stop_state_t      stop_state;
    stop_state_t      stop_next;
    logic             unused_addr;

    assign unused_addr = &{1'b0, mem_a[31:18]};

    // Request decode; nothing on the bus side acts while rdy_in is low.
    always_comb begin
        io_sel       = (mem_a[17:16] == IO_SEL);
        io_off       = mem_a[2:0];
        bus_wr       = rdy_in && mem_wr;
        bus_rd       = rdy_in && !mem_wr;
        stop_req     = bus_wr && io_sel && (io_off == IO_CLK);
        // Zero bytes to the UART port are ignored; the stop marker is a forced zero.
        tx_push      = stop_req || (bus_wr && io_sel && (io_off == IO_UART) && (mem_dout != 8'h00));
        tx_push_data = stop_req ? 8'h00 : mem_dout;
        tx_pop       = tx_valid && tx_ready;
        rx_pop       = bus_rd && io_sel && (io_off == IO_UART) && (rx_count != '0);
    end

    // Read data mux for the registered return path.
    always_comb begin
        rd_data = 8'h00;
        if (!io_sel) begin
            rd_data = ram[mem_a[ADDR_WIDTH-1:0]];
        end else begin
            case (io_off)
                IO_UART:          rd_data = (rx_count != '0) ? rx_head : 8'h00;
                IO_CLK:           rd_data = cycle_cnt[7:0];
                3'd5, 3'd6, 3'd7: rd_data = byte_sel(snapshot, io_off[1:0]);
                default:          rd_data = 8'h00;
            endcase
        end
    end

    // Byte RAM; a write is visible to a read on the following cycle.
    always_ff @(posedge clk_in) begin
        if (bus_wr && !io_sel) ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
    end

    // Read return, cycle counter and snapshot (offset 4 latches, 5..7 replay).
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_din   <= 8'h00;
            cycle_cnt <= 32'd0;
            snapshot  <= 32'd0;
        end else if (rdy_in) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (bus_rd) mem_din <= rd_data;
            if (bus_rd && io_sel && (io_off == IO_CLK)) snapshot <= cycle_cnt;
        end
    end

    memio_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (tx_push),
        .push_data (tx_push_data),
        .pop       (tx_pop),
        .head_c    (tx_data),
        .count     (tx_count)
    );

    memio_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head_c    (rx_head),
        .count     (rx_count)
    );

    assign tx_valid       = (tx_count != '0);
    // Two slots of headroom absorb a write already issued by the core.
    assign io_buffer_full = (tx_count >= TX_CW'(TX_DEPTH - 2));

    // Stop FSM next state.
    always_comb begin
        stop_next = stop_state;
        case (stop_state)
            ST_RUN:     if (stop_req) stop_next = ST_DRAIN;
            ST_DRAIN:   if (!tx_valid) stop_next = ST_STOPPED;
            ST_STOPPED: stop_next = ST_STOPPED;
            default:    stop_next = ST_RUN;
        endcase
    end

    // Stop FSM state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stop_state   <= ST_RUN;
            program_stop <= 1'b0;
        end else begin
            stop_state   <= stop_next;
            program_stop <= (stop_next == ST_STOPPED);
        end
    end

`ifdef MEMIO_TX_OVERFLOW_FLAG_EN
    // Sticky flag for any tx byte dropped because the FIFO was full.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_overflow <= 1'b0;
        end else if (tx_push && (tx_count == TX_CW'(TX_DEPTH)) && !tx_pop) begin
            tx_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

    localparam int TX_DEPTH = 8;
    localparam int RX_DEPTH = 8;
    localparam logic [31:0] IDLE_A = 32'h0003_0001;
    localparam int S_RUN = 0;
    localparam int S_DRAIN = 1;
    localparam int S_STOPPED = 2;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        program_stop;
    logic        ovf_obs;
`ifdef MEMIO_TX_OVERFLOW_FLAG_EN
    logic        tx_overflow;
    assign ovf_obs = tx_overflow;
`else
    assign ovf_obs = 1'b0;
`endif

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .program_stop   (program_stop)
`ifdef MEMIO_TX_OVERFLOW_FLAG_EN
        ,
        .tx_overflow    (tx_overflow)
`endif
    );

    initial forever #5 clk_in = ~clk_in;

    typedef struct {
        int         due;
        logic [7:0] din;
        bit         iobf;
        bit         txv;
        bit         stop;
        bit         ovf;
    } st_exp_t;

    st_exp_t     sb_st[$];
    logic [7:0]  sb_tx[$];
    logic [7:0]  m_tx[$];
    logic [7:0]  m_rx[$];
    logic [7:0]  m_ram[int];
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic [7:0]  m_din;
    int          m_state;
    bit          m_ovf;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    st_exp_t     mon_e;
    logic [7:0]  mon_b;
    logic [17:0] pool[8];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: status/read expectations by due cycle, tx stream on handshake.
    always @(negedge clk_in) begin
        while (sb_st.size() > 0 && sb_st[0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL status_missed actual=none expected_due=%0d cycle=%0d", sb_st[0].due, cyc);
            sb_st.delete(0);
        end
        if (sb_st.size() > 0 && sb_st[0].due == cyc) begin
            mon_e = sb_st.pop_front();
            chk("mem_din", 32'(mem_din), 32'(mon_e.din));
            chk("io_buffer_full", 32'(io_buffer_full), 32'(mon_e.iobf));
            chk("tx_valid", 32'(tx_valid), 32'(mon_e.txv));
            chk("program_stop", 32'(program_stop), 32'(mon_e.stop));
`ifdef MEMIO_TX_OVERFLOW_FLAG_EN
            chk("tx_overflow", 32'(ovf_obs), 32'(mon_e.ovf));
`endif
        end
        if (!rst_in && tx_valid && tx_ready) begin
            if (sb_tx.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected actual=0x%0h expected=none cycle=%0d", tx_data, cyc);
            end else begin
                mon_b = sb_tx.pop_front();
                chk("tx_data", 32'(tx_data), 32'(mon_b));
            end
        end
    end

    // One bus cycle: drive inputs, advance the reference model to the next edge.
    task automatic step(input bit rdy, input logic [31:0] a, input bit wr, input logic [7:0] dout,
                        input bit txr, input logic [7:0] rxd, input bit rxv);
        bit         io;
        int         off;
        int         idx;
        bit         tx_pop;
        bit         rx_pop;
        bit         tx_push;
        bit         stop_req;
        bit         was_empty;
        int         pre;
        logic [7:0] tx_byte;
        st_exp_t    e;
        rdy_in = rdy; mem_a = a; mem_wr = wr; mem_dout = dout;
        tx_ready = txr; rx_data = rxd; rx_valid = rxv;
        io = (a[17:16] == 2'b11);
        off = int'(a[2:0]);
        idx = int'(a[16:0]);
        tx_pop = txr && (m_tx.size() > 0);
        was_empty = (m_tx.size() == 0);
        rx_pop = 0; tx_push = 0; stop_req = 0; tx_byte = 8'h00;
        if (rdy) begin
            if (wr) begin
                if (!io) m_ram[idx] = dout;
                else if (off == 0 && dout != 8'h00) begin tx_push = 1; tx_byte = dout; end
                else if (off == 4) begin tx_push = 1; tx_byte = 8'h00; stop_req = 1; end
            end else if (!io) begin
                m_din = m_ram.exists(idx) ? m_ram[idx] : 8'h00;
            end else begin
                case (off)
                    0: begin
                        if (m_rx.size() > 0) begin m_din = m_rx[0]; rx_pop = 1; end
                        else m_din = 8'h00;
                    end
                    4: begin m_snap = m_cnt; m_din = m_cnt[7:0]; end
                    5: m_din = m_snap[15:8];
                    6: m_din = m_snap[23:16];
                    7: m_din = m_snap[31:24];
                    default: m_din = 8'h00;
                endcase
            end
            m_cnt = m_cnt + 32'd1;
        end
        pre = m_tx.size();
        if (tx_pop) m_tx.delete(0);
        if (tx_push) begin
            if (pre < TX_DEPTH || tx_pop) begin m_tx.push_back(tx_byte); sb_tx.push_back(tx_byte); end
            else m_ovf = 1;
        end
        pre = m_rx.size();
        if (rx_pop) m_rx.delete(0);
        if (rxv && (pre < RX_DEPTH || rx_pop)) m_rx.push_back(rxd);
        if (m_state == S_RUN && stop_req) m_state = S_DRAIN;
        else if (m_state == S_DRAIN && was_empty) m_state = S_STOPPED;
        e.due = cyc + 1;
        e.din = m_din;
        e.iobf = (m_tx.size() >= TX_DEPTH - 2);
        e.txv = (m_tx.size() != 0);
        e.stop = (m_state == S_STOPPED);
        e.ovf = m_ovf;
        sb_st.push_back(e);
        @(posedge clk_in); #1;
    endtask

    task automatic idle(input bit txr);
        step(1'b1, IDLE_A, 1'b0, 8'h00, txr, 8'h00, 1'b0);
    endtask

    // Reset asserted while a read of 'a' is in flight.
    task automatic do_reset(input logic [31:0] a);
        st_exp_t e;
        rdy_in = 1'b1; mem_a = a; mem_wr = 1'b0; mem_dout = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        @(negedge clk_in); #1;
        rst_in = 1'b1;
        sb_st.delete(); sb_tx.delete(); m_tx.delete(); m_rx.delete();
        m_cnt = 32'd0; m_snap = 32'd0; m_din = 8'h00; m_state = S_RUN; m_ovf = 0;
        e.due = cyc + 1; e.din = 8'h00; e.iobf = 0; e.txv = 0; e.stop = 0; e.ovf = 0;
        sb_st.push_back(e);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_tx.size() > 0; i++) idle(1'b1);
        chk("tx_drained", 32'(sb_tx.size()), 32'd0);
    endtask

    function automatic logic [31:0] io_addr(input logic [2:0] off);
        return {14'($urandom()), 2'b11, 13'($urandom()), off};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running expected=finished cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0; mem_a = 32'd0; mem_wr = 1'b0; mem_dout = 8'h00;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        m_cnt = 0; m_snap = 0; m_din = 0; m_state = S_RUN; m_ovf = 0;
        repeat (2) @(posedge clk_in);
        #1;
        do_reset(IDLE_A);

        // RAM write then read-after-write.
        step(1, 32'h0000_0010, 1, 8'hA5, 0, 8'h00, 0);
        step(1, 32'h0000_0010, 0, 8'h00, 0, 8'h00, 0);
        // Reset hits an in-flight read: mem_din must clear.
        do_reset(32'h0000_0010);
        step(1, 32'h0000_0010, 0, 8'h00, 0, 8'h00, 0);
        idle(0);

        // tx writes with a zero byte ignored, then drain.
        step(1, 32'h0003_0000, 1, 8'h41, 0, 8'h00, 0);
        step(1, 32'h0003_0000, 1, 8'h00, 0, 8'h00, 0);
        step(1, 32'h0003_0000, 1, 8'h42, 0, 8'h00, 0);
        drain();

        // Fill tx: almost-full after 6, drops once full.
        do_reset(IDLE_A);
        for (int i = 0; i < 10; i++) step(1, 32'h0003_0000, 1, 8'(8'h10 + i), 0, 8'h00, 0);
        step(1, 32'h0003_0000, 1, 8'h77, 1, 8'h00, 0);
        drain();

        // Counter snapshot at cycle 300, coherent byte reads.
        do_reset(IDLE_A);
        while (m_cnt != 32'd300) idle(0);
        step(1, 32'h0003_0004, 0, 8'h00, 0, 8'h00, 0);
        chk("snap_b0_expected", 32'(m_din), 32'h2C);
        step(1, 32'h0003_0005, 0, 8'h00, 0, 8'h00, 0);
        step(0, 32'h0003_0006, 0, 8'h00, 0, 8'h00, 0);
        step(1, 32'h0003_0006, 0, 8'h00, 0, 8'h00, 0);
        step(1, 32'h0003_0007, 0, 8'h00, 0, 8'h00, 0);
        idle(0);

        // rx push then two reads.
        step(1, IDLE_A, 0, 8'h00, 0, 8'h7F, 1);
        step(1, 32'h0003_0000, 0, 8'h00, 0, 8'h00, 0);
        step(1, 32'h0003_0000, 0, 8'h00, 0, 8'h00, 0);
        idle(0);

        // Stop with two bytes queued; rdy toggling must not disturb it.
        do_reset(IDLE_A);
        step(1, 32'h0003_0000, 1, 8'h61, 0, 8'h00, 0);
        step(1, 32'h0003_0000, 1, 8'h62, 0, 8'h00, 0);
        step(1, 32'h0003_0004, 1, 8'h55, 0, 8'h00, 0);
        for (int i = 0; i < 12; i++) step(1'(i % 2), IDLE_A, 0, 8'h00, 1, 8'h00, 0);
        chk("program_stop_sticky", 32'(program_stop), 32'd1);

        // Randomized traffic against the reference model.
        do_reset(IDLE_A);
        for (int i = 0; i < 8; i++) begin
            pool[i] = 18'($urandom());
            if (pool[i][17:16] == 2'b11) pool[i][16] = 1'b0;
        end
        for (int n = 0; n < 2500; n++) begin
            int          r;
            int          p;
            bit          rdy;
            bit          txr;
            bit          rxv;
            logic [31:0] a;
            logic [7:0]  d;
            r = int'($urandom_range(0, 99));
            p = int'($urandom_range(0, 7));
            rdy = ($urandom_range(0, 9) != 0);
            txr = ($urandom_range(0, 2) == 0);
            rxv = ($urandom_range(0, 9) < 3);
            d = 8'($urandom());
            a = {14'($urandom()), pool[p]};
            if (r < 40 && !(r >= 20 && m_ram.exists(int'(pool[p][16:0])))) begin
                step(rdy, a, 1, d, txr, 8'($urandom()), rxv);
            end else if (r < 40) begin
                step(rdy, a, 0, 8'h00, txr, 8'($urandom()), rxv);
            end else if (r < 55) begin
                if ($urandom_range(0, 3) == 0) d = 8'h00;
                step(rdy, io_addr(3'd0), 1, d, txr, 8'($urandom()), rxv);
            end else if (r < 65) begin
                step(rdy, io_addr(3'd0), 0, 8'h00, txr, 8'($urandom()), rxv);
            end else if (r < 75) begin
                step(rdy, io_addr(3'($urandom_range(4, 7))), 0, 8'h00, txr, 8'($urandom()), rxv);
            end else if (r < 85) begin
                a = io_addr(3'($urandom_range(1, 3)));
                if ($urandom_range(0, 1) == 1) a[2] = 1'b1;
                if (a[2:0] == 3'd4) a[0] = 1'b1;
                step(rdy, a, 1, d, txr, 8'($urandom()), rxv);
            end else begin
                step(rdy, io_addr(3'($urandom_range(1, 3))), 0, 8'h00, txr, 8'($urandom()), rxv);
            end
        end
        drain();
        idle(0);
        @(negedge clk_in); #1;
        chk("scoreboard_empty", 32'(sb_st.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Memory/IO responder on the far side of the CPU's byte-wide memory bus: it accepts `mem_a`, `mem_wr` and `mem_dout` from the core and returns `mem_din` one cycle later. It backs a 128 KB byte RAM and the IO window at `0x30000`, which covers UART tx/rx, the cycle counter and program stop. It drives `io_buffer_full` back to the core and sits between the CPU top and the UART/host-interface logic.

## Interface
- `ADDR_WIDTH`, 17: RAM index width (2^17 bytes).
- `TX_DEPTH`, 8: tx FIFO entries, power of two, at least 4.
- `RX_DEPTH`, 8: rx FIFO entries, power of two, at least 2.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset. Asynchronous, active-high.
- `rdy_in`  in  1  bus requests are honoured only when high.
- `mem_a`  in  32  request address. Only bits 17:0 are decoded.
- `mem_wr`  in  1  1 = write, 0 = read.
- `mem_dout`  in  8  write data from the CPU.
- `mem_din`  out  8  read data to the CPU, registered.
- `io_buffer_full`  out  1  tx FIFO almost full.
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_valid`  out  1  tx FIFO not empty.
- `tx_ready`  in  1  transmitter accepts `tx_data` this cycle.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  single-cycle push of `rx_data`.
- `program_stop`  out  1  sticky; program finished and tx drained.
- `tx_overflow`  out  1  sticky overflow flag. Present only with `MEMIO_TX_OVERFLOW_FLAG_EN`.

## Operation
- Decode:
  - `mem_a[17:16]==2'b11` selects IO. Offset is `mem_a[2:0]`.
  - Otherwise RAM at index `mem_a[ADDR_WIDTH-1:0]`.
- RAM:
  - Write: the byte is stored at the clock edge.
  - Read: the byte appears on `mem_din` the next cycle.
  - Read-after-write to the same address on the next cycle returns the new byte.
- IO reads, returned next cycle:
  - `0x30000`: pop the rx FIFO and return the byte. If the FIFO is empty, return `0x00` and pop nothing.
  - `0x30004`: latch the 32-bit cycle counter into a snapshot register and return the snapshot's byte 0.
  - `0x30005`–`0x30007`: return snapshot bytes 1–3, little-endian. These reads do not re-latch, so a 4-byte read sequence is coherent.
  - Any other IO offset returns `0x00`.
- IO writes:
  - `0x30000`: push `mem_dout` into the tx FIFO. Byte `0x00` is ignored.
  - `0x30004`: stop request. Enqueue `0x00` into the tx FIFO and move the stop FSM from RUN to DRAIN. The `0x00` is forced even though `0x30000` ignores zero bytes.
- `rdy_in` low:
  - No RAM write, no FIFO pop or push from the bus, no snapshot latch.
  - `mem_din` holds its value.
  - The cycle counter holds.
  - The UART side (`tx_ready` pops, `rx_valid` pushes) continues.
- Cycle counter: 32 bits, increments every cycle with `rdy_in` high, wraps from `0xFFFFFFFF` to 0.
- `io_buffer_full` = tx count ≥ `TX_DEPTH-2`. The headroom covers one write already issued.
- tx push when the FIFO is full: the byte is dropped.
- rx push when the FIFO is full: the byte is dropped.
- Simultaneous push and pop on either FIFO: count is unchanged, and data order is preserved.
  - When the FIFO is empty, the pushed byte is not visible to a same-cycle pop; that pop sees empty.
- Stop FSM:
  - RUN → DRAIN on a `0x30004` write.
  - DRAIN → STOPPED when the tx FIFO is empty.
  - STOPPED is terminal until reset.
  - `program_stop` = (state == STOPPED).
  - Further tx writes in DRAIN or STOPPED are still accepted.

## Timing
- Read latency is exactly 1 cycle for RAM and IO. Write latency is 0 (done at the edge).
- Back-to-back requests every cycle are supported; there are no wait states.
- Reset values:
  - `mem_din`=0, `tx_valid`=0, `io_buffer_full`=0, `program_stop`=0, `tx_overflow`=0.
  - Counter and snapshot = 0.
  - FIFOs empty.
  - FSM in RUN.
- RAM contents are not reset.
- Reset asserted mid-operation: all registers above return to reset values immediately; an in-flight read returns 0.
- `tx_data` is valid whenever `tx_valid` is high. A pop occurs on `tx_valid && tx_ready`.

## Configuration
- `MEMIO_TX_OVERFLOW_FLAG_EN` defined:
  - A tx push while the FIFO is full sets sticky `tx_overflow`, cleared only by reset.
  - A forced stop byte dropped while full also sets it.
- Not defined: the port and its logic are absent, and overflows drop silently.

## Structure
- Shared package `memio_pkg`:
  - IO base and offset constants (`IO_UART = 3'd0`, `IO_CLK = 3'd4`).
  - Stop FSM state enum (RUN, DRAIN, STOPPED).
  - IO-select decode constant `2'b11`.
- Sub-module `memio_fifo`: parameterised synchronous FIFO with push, pop, data and count. Instantiated twice, for tx and rx.
- RAM is inferred inside `mem_io_responder`.

## Test plan
- Write `0xA5` to `0x00010`, read `0x00010` on the next cycle → `mem_din==0xA5` one cycle after the read.
- Write `0x41`, `0x00`, `0x42` to `0x30000` with `tx_ready=0` → tx count 2. Then `tx_ready=1` → `tx_data` sequence `0x41`, `0x42`.
- 7 consecutive tx writes with `TX_DEPTH=8` and `tx_ready=0` → `io_buffer_full` rises after the 6th. Further writes after the FIFO is full are dropped; `tx_overflow=1` when enabled.
- Reads at cycle 300:
  - Read `0x30004` at counter `0x0000012C` → `mem_din=0x2C`.
  - Then read `0x30005`, `0x30006`, `0x30007` → `0x01`, `0x00`, `0x00`, despite the counter advancing.
- `rx_valid` with `0x7F`, then read `0x30000` → `0x7F`. A second read → `0x00`.
- Write any byte to `0x30004` with 2 bytes queued → `program_stop` rises the cycle after the third tx pop (`0x00`). It stays high; the `rdy_in` low/high toggles have no effect on it.
